control_sequencer: RTL and testbench

// Microprogram next-state sequencer for the multicycle control unit. Holds the current

---
 rtl/control_sequencer.sv | 122 ++++++++++++
 tb/tb_control_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: microprogram next-state sequencer for the multicycle
// control unit. Selects the next control-store address from dispatch, jump,
// increment or fixed vectors, sequences MOC memory waits with a watchdog, and
// traps undecodable instructions and memory timeouts.
module control_sequencer #(
  parameter int STATE_W       = 7,
  parameter int RESET_STATE   = 0,
  parameter int FETCH_STATE   = 1,
  parameter int ILLEGAL_STATE = 126,
  parameter int ERROR_STATE   = 127,
  parameter int MOC_TIMEOUT   = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [STATE_W-1:0] State_Sel,
  input  logic [2:0]         Next_Ctl,
  input  logic               Inv,
  input  logic               Cond,
  input  logic [STATE_W-1:0] CR_Addr,
  input  logic               MOC,
  input  logic               Stall,
  output logic [STATE_W-1:0] State,
  output logic               Mem_Wait,
  output logic               Illegal_Op,
  output logic               Mem_Timeout
);

  // Wait counter must reach MOC_TIMEOUT-1; keep at least one bit when disabled.
  localparam int CNT_W = (MOC_TIMEOUT == 0) ? 1 : $clog2(MOC_TIMEOUT + 1);

  localparam logic [STATE_W-1:0] RESET_S   = STATE_W'(RESET_STATE);
  localparam logic [STATE_W-1:0] FETCH_S   = STATE_W'(FETCH_STATE);
  localparam logic [STATE_W-1:0] ILLEGAL_S = STATE_W'(ILLEGAL_STATE);
  localparam logic [STATE_W-1:0] ERROR_S   = STATE_W'(ERROR_STATE);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(MOC_TIMEOUT - 1);
  localparam bit                 WDOG_EN   = (MOC_TIMEOUT != 0);

  typedef enum logic [2:0] {
    NC_DISPATCH  = 3'b000,
    NC_FETCH     = 3'b001,
    NC_INC       = 3'b010,
    NC_JUMP      = 3'b011,
    NC_MOC_WAIT  = 3'b100,
    NC_COND      = 3'b101,
    NC_RESET_VEC = 3'b110,
    NC_HOLD      = 3'b111
  } next_ctl_e;

  next_ctl_e          mode;
  logic [STATE_W-1:0] state_q, state_d;
  logic [STATE_W-1:0] state_inc;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               illegal_q, illegal_d;
  logic               timeout_q, timeout_d;

  assign mode      = next_ctl_e'(Next_Ctl);
  assign state_inc = state_q + STATE_W'(1);

  // Next-state, wait-counter and trap-pulse selection.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a value unassigned and infer a latch.
    state_d   = state_q;
    cnt_d     = '0;
    illegal_d = 1'b0;
    timeout_d = 1'b0;
    if (Stall) begin
      cnt_d = cnt_q;
    end else begin
      unique case (mode)
        NC_DISPATCH: begin
          if (State_Sel == '0) begin
            state_d   = ILLEGAL_S;
            illegal_d = 1'b1;
          end else begin
            state_d = State_Sel;
          end
        end
        NC_FETCH:     state_d = FETCH_S;
        NC_INC:       state_d = state_inc;
        NC_JUMP:      state_d = CR_Addr;
        NC_MOC_WAIT: begin
          if (MOC) begin
            // MOC wins over a timeout landing on the same edge.
            state_d = state_inc;
          end else if (WDOG_EN && (cnt_q == CNT_LAST)) begin
            state_d   = ERROR_S;
            timeout_d = 1'b1;
          end else begin
            cnt_d = WDOG_EN ? cnt_q + CNT_W'(1) : '0;
          end
        end
        NC_COND:      state_d = (Cond ^ Inv) ? CR_Addr : state_inc;
        NC_RESET_VEC: state_d = RESET_S;
        NC_HOLD:      state_d = state_q;
        default:      state_d = state_q;
      endcase
    end
  end

  // State, wait counter and trap pulses, asynchronously reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= RESET_S;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  assign State       = state_q;
  assign Illegal_Op  = illegal_q;
  assign Mem_Timeout = timeout_q;
  assign Mem_Wait    = (mode == NC_MOC_WAIT) && !MOC && !Stall;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed vectors for control_sequencer with a
// scoreboard queue of expected post-edge responses and a separate monitor.
module tb_control_sequencer;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [6:0] State_Sel = '0;
  logic [2:0] Next_Ctl = 3'b111;
  logic       Inv = 1'b0;
  logic       Cond = 1'b0;
  logic [6:0] CR_Addr = '0;
  logic       MOC = 1'b0;
  logic       Stall = 1'b0;
  logic [6:0] State;
  logic       Mem_Wait;
  logic       Illegal_Op;
  logic       Mem_Timeout;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    logic [6:0] st;
    logic       ill;
    logic       to;
    logic       mw;
  } exp_t;

  exp_t sb[$];

  control_sequencer #(.MOC_TIMEOUT(4)) dut (
    .Clk(Clk), .Reset(Reset), .State_Sel(State_Sel), .Next_Ctl(Next_Ctl),
    .Inv(Inv), .Cond(Cond), .CR_Addr(CR_Addr), .MOC(MOC), .Stall(Stall),
    .State(State), .Mem_Wait(Mem_Wait), .Illegal_Op(Illegal_Op),
    .Mem_Timeout(Mem_Timeout)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs and queue the response expected after the edge.
  task automatic apply(input string tag, input logic [2:0] ctl, input logic [6:0] sel,
                       input logic [6:0] cr, input logic moc, input logic stall,
                       input logic cond, input logic inv, input logic [6:0] est,
                       input logic eill, input logic eto, input logic emw);
    exp_t e;
    Next_Ctl = ctl; State_Sel = sel; CR_Addr = cr; MOC = moc;
    Stall = stall; Cond = cond; Inv = inv;
    e.tag = tag; e.st = est; e.ill = eill; e.to = eto; e.mw = emw;
    sb.push_back(e);
  endtask

  task automatic d(input string tag, input logic [2:0] ctl, input logic [6:0] sel,
                   input logic [6:0] cr, input logic moc, input logic stall,
                   input logic cond, input logic inv, input logic [6:0] est,
                   input logic eill, input logic eto, input logic emw);
    @(negedge Clk);
    apply(tag, ctl, sel, cr, moc, stall, cond, inv, est, eill, eto, emw);
  endtask

  task automatic jmp(input logic [6:0] a);
    d("jump", 3'b011, 7'd0, a, 1'b0, 1'b0, 1'b0, 1'b0, a, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait0(input string tag, input logic [6:0] st);
    d(tag, 3'b100, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, st, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic wait1(input string tag, input logic [6:0] st);
    d(tag, 3'b100, 7'd0, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, st, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic cond_t(input string tag, input logic c, input logic i, input logic [6:0] st);
    d(tag, 3'b101, 7'd0, 7'd40, 1'b0, 1'b0, c, i, st, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: after each rising edge, compare outputs with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check({e.tag, "/state"},   32'(State),       32'(e.st));
        check({e.tag, "/illegal"}, 32'(Illegal_Op),  32'(e.ill));
        check({e.tag, "/timeout"}, 32'(Mem_Timeout), 32'(e.to));
        check({e.tag, "/mem_wait"}, 32'(Mem_Wait),   32'(e.mw));
      end
    end
  end

  initial begin
    int n;
    @(posedge Clk);
    #1;
    check("reset/state",   32'(State),       32'd0);
    check("reset/illegal", 32'(Illegal_Op),  32'd0);
    check("reset/timeout", 32'(Mem_Timeout), 32'd0);

    // Reset mid-wait with counter at 3, then a fresh wait must count from 0.
    @(negedge Clk);
    Reset = 1'b0;
    apply("jump13", 3'b011, 7'd0, 7'd13, 1'b0, 1'b0, 1'b0, 1'b0, 7'd13, 1'b0, 1'b0, 1'b0);
    wait0("rw1", 7'd13);
    wait0("rw2", 7'd13);
    wait0("rw3", 7'd13);
    @(negedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    check("async_rst/state",   32'(State),       32'd0);
    check("async_rst/illegal", 32'(Illegal_Op),  32'd0);
    check("async_rst/timeout", 32'(Mem_Timeout), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    apply("pr_w1", 3'b100, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b1);
    wait0("pr_w2", 7'd0);
    wait0("pr_w3", 7'd0);
    wait1("pr_moc", 7'd1);
    jmp(7'd50);
    d("fetch", 3'b001, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd1, 1'b0, 1'b0, 1'b0);

    // Dispatch, illegal trap, one-cycle pulse.
    d("disp6", 3'b000, 7'd6, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd6, 1'b0, 1'b0, 1'b0);
    d("disp0", 3'b000, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd126, 1'b1, 1'b0, 1'b0);
    d("hold_ill", 3'b111, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd126, 1'b0, 1'b0, 1'b0);

    // MOC wait: three low cycles then MOC.
    jmp(7'd13);
    wait0("mw1", 7'd13);
    wait0("mw2", 7'd13);
    wait0("mw3", 7'd13);
    wait1("mw_moc", 7'd14);
    d("inc_moc_ign", 3'b010, 7'd0, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 7'd15, 1'b0, 1'b0, 1'b0);

    // Timeout after 4 wait edges, then MOC on the 4th cycle wins.
    jmp(7'd13);
    wait0("to1", 7'd13);
    wait0("to2", 7'd13);
    wait0("to3", 7'd13);
    d("to4", 3'b100, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd127, 1'b0, 1'b1, 1'b1);
    d("hold_to", 3'b111, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd127, 1'b0, 1'b0, 1'b0);
    jmp(7'd13);
    wait0("tm1", 7'd13);
    wait0("tm2", 7'd13);
    wait0("tm3", 7'd13);
    wait1("tm4_moc", 7'd14);

    // Cond/Inv branching.
    jmp(7'd11);
    cond_t("c1i0", 1'b1, 1'b0, 7'd40);
    jmp(7'd11);
    cond_t("c1i1", 1'b1, 1'b1, 7'd12);
    jmp(7'd11);
    cond_t("c0i1", 1'b0, 1'b1, 7'd40);
    jmp(7'd11);
    cond_t("c0i0", 1'b0, 1'b0, 7'd12);

    // Wrap, stall hold, stall clears pulses.
    jmp(7'd127);
    d("inc_wrap", 3'b010, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
    jmp(7'd20);
    d("stall_jump", 3'b011, 7'd0, 7'd5, 1'b0, 1'b1, 1'b0, 1'b0, 7'd20, 1'b0, 1'b0, 1'b0);
    d("disp0_b", 3'b000, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd126, 1'b1, 1'b0, 1'b0);
    d("stall_pulse", 3'b000, 7'd0, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0, 7'd126, 1'b0, 1'b0, 1'b0);

    // Stall holds the wait counter.
    jmp(7'd13);
    wait0("sh1", 7'd13);
    wait0("sh2", 7'd13);
    d("sh_st1", 3'b100, 7'd0, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0, 7'd13, 1'b0, 1'b0, 1'b0);
    d("sh_st2", 3'b100, 7'd0, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0, 7'd13, 1'b0, 1'b0, 1'b0);
    wait0("sh3", 7'd13);
    d("sh4", 3'b100, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd127, 1'b0, 1'b1, 1'b1);

    // Leaving MOC_WAIT clears the counter.
    jmp(7'd13);
    wait0("cl1", 7'd13);
    wait0("cl2", 7'd13);
    d("cl_inc", 3'b010, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd14, 1'b0, 1'b0, 1'b0);
    wait0("cl3", 7'd14);
    wait0("cl4", 7'd14);
    wait0("cl5", 7'd14);
    wait1("cl_moc", 7'd15);
    d("reset_vec", 3'b110, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0);

    @(negedge Clk);
    Next_Ctl = 3'b111; MOC = 1'b0; Stall = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 10) begin
      @(negedge Clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d responses pending, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
